mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one Avalon-style memory port with waitrequest between the CPU instruction-fetch path and the load/store data path.
- Sits between the fetch/memory pipeline stages and the top-level bus.
- Sequences each transfer through a small FSM and holds bus signals stable under waitrequest.
- Data accesses win by default. A starvation counter guarantees fetch progress.

Parameters:
- RESET_VECTOR, 32'hBFC00000: fetch address that is valid immediately after reset; informational only, reported on boot_addr.
- STARVE_LIMIT, 4: consecutive data grants allowed while a fetch is pending; after that many, fetch is forced next.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  fetch request; held until i_valid or i_err
- i_addr  in  32  fetch byte address
- i_rdata  out  32  fetched word, valid while i_valid=1
- i_valid  out  1  one-cycle pulse: fetch complete
- i_err  out  1  one-cycle pulse: misaligned fetch, no bus access
- d_read  in  1  data load request; held until d_done
- d_write  in  1  data store request; held until d_done
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_byteen  in  4  store/load byte enables
- d_rdata  out  32  load data, valid while d_done=1
- d_done  out  1  one-cycle pulse: data transfer complete
- m_read  out  1  bus read strobe
- m_write  out  1  bus write strobe
- m_addr  out  32  bus word address; bits [1:0] always 0
- m_wdata  out  32  bus write data
- m_byteen  out  4  bus byte enables
- m_waitrequest  in  1  bus stall
- m_rdata  in  32  bus read data, valid on accept cycle
- boot_addr  out  32  constant RESET_VECTOR

Behaviour:
- Reset (async, rst_n=0):
  - State returns to IDLE; starve count clears to 0.
  - m_read, m_write, i_valid, i_err and d_done go to 0.
  - m_addr, m_wdata, m_byteen, i_rdata and d_rdata go to 0.
  - An in-flight transfer is abandoned. The requester re-issues it after reset.
- States: IDLE, FETCH, DATA, RESP. All outputs are registered.
- IDLE arbitration, evaluated each cycle:
  - If (d_read|d_write) and (starve<STARVE_LIMIT or !i_req), go to DATA.
  - Otherwise, if i_req and i_addr[1:0]==0, go to FETCH.
  - Otherwise, if i_req with a misaligned address, pulse i_err next cycle and stay IDLE.
- Entering FETCH:
  - m_read=1; m_addr={i_addr[31:2],2'b00}; m_byteen=4'hF.
- Entering DATA:
  - m_addr={d_addr[31:2],2'b00}; m_byteen=d_byteen.
  - If d_write: m_write=1 and m_wdata=d_wdata.
  - Else: m_read=1.
  - d_read and d_write together is treated as a write.
- FETCH/DATA hold: while m_waitrequest=1, every m_* output stays unchanged.
- Accept: the first edge with m_waitrequest=0.
  - Drop the strobes and go to RESP.
  - Capture m_rdata into i_rdata (fetch) or into d_rdata (data read).
- RESP:
  - Pulse i_valid or d_done for one cycle, then return to IDLE.
  - The requester may drop its request in the same cycle as the pulse.
- Latency with zero wait states: request seen in cycle 0, strobe in cycle 1, pulse in cycle 2. Back-to-back throughput is one transfer per 3 cycles. Each wait cycle adds one cycle.
- Starvation counter:
  - Increments on each DATA grant taken while i_req=1, saturating at STARVE_LIMIT.
  - Clears on each FETCH grant or i_err.
  - Clears on any IDLE cycle with i_req=0.
- i_rdata and d_rdata hold their last captured value until the next capture.
- Requests asserted during FETCH, DATA or RESP are ignored until IDLE. No request queueing.
- At most one strobe is ever high. m_read and m_write are never high together.

Test Plan:
- Reset, then i_req=1 with i_addr=32'hBFC00000, waitrequest=0, m_rdata=32'h24020005.
  -> Cycle 1: m_read=1, m_addr=BFC00000, m_byteen=F.
  -> Cycle 2: i_valid=1, i_rdata=24020005.
- d_write=1 with d_addr=32'h00001006, d_wdata=32'hDEADBEEF, d_byteen=4'b1100, waitrequest high for 3 cycles.
  -> m_write held 4 cycles, m_addr=00001004, m_wdata/m_byteen stable.
  -> d_done pulses exactly once, 1 cycle after accept.
- i_req and d_read both asserted at the same time.
  -> DATA granted first; d_done arrives before i_valid.
  -> Fetch then issued with no idle gap beyond RESP.
- d_read continuously re-asserted with i_req held, STARVE_LIMIT=4.
  -> Exactly 4 data transfers, then 1 fetch, then data resumes.
- i_req=1 with i_addr=32'hBFC00002.
  -> i_err pulses; m_read never asserts; starve count is 0.
- rst_n=0 mid-DATA while waitrequest=1.
  -> m_write drops immediately (async) and state returns to IDLE.
  -> No d_done pulse for the abandoned transfer.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module   : mem_port_arbiter_if
// Purpose  : Fetch, load/store and Avalon-style bus signals of the port arbiter
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_valid;
  logic        i_err;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_byteen;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_byteen;
  logic        m_waitrequest;
  logic [31:0] m_rdata;
  logic [31:0] boot_addr;

  // The arbiter masters the memory bus and answers both pipeline requesters.
  modport master (
    input  i_req, i_addr, d_read, d_write, d_addr, d_wdata, d_byteen,
    input  m_waitrequest, m_rdata,
    output i_rdata, i_valid, i_err, d_rdata, d_done,
    output m_read, m_write, m_addr, m_wdata, m_byteen, boot_addr
  );

  modport slave (
    output i_req, i_addr, d_read, d_write, d_addr, d_wdata, d_byteen,
    output m_waitrequest, m_rdata,
    input  i_rdata, i_valid, i_err, d_rdata, d_done,
    input  m_read, m_write, m_addr, m_wdata, m_byteen, boot_addr
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one waitrequest memory port between fetch and load/store
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.master bus
);

  localparam int unsigned           c_cnt_w      = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_cnt_w-1:0]    c_starve_max = c_cnt_w'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t               state_q;
  logic [c_cnt_w-1:0]   starve_q;
  logic                 m_read_q;
  logic                 m_write_q;
  logic [31:0]          m_addr_q;
  logic [31:0]          m_wdata_q;
  logic [3:0]           m_byteen_q;
  logic [31:0]          i_rdata_q;
  logic [31:0]          d_rdata_q;
  logic                 i_valid_q;
  logic                 i_err_q;
  logic                 d_done_q;

  logic w_i_req;
  logic w_d_req;
  logic w_grant_data;
  logic w_fetch_ok;
  logic w_unused;

  // A fetch still held during its own i_err pulse is not a fresh request.
  assign w_i_req      = bus.i_req & ~i_err_q;
  assign w_d_req      = bus.d_read | bus.d_write;
  assign w_grant_data = w_d_req & ((starve_q < c_starve_max) | ~w_i_req);
  assign w_fetch_ok   = w_i_req & (bus.i_addr[1:0] == 2'b00);
  assign w_unused     = &{1'b0, bus.d_addr[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      m_read_q   <= 1'b0;
      m_write_q  <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_byteen_q <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      i_valid_q  <= 1'b0;
      i_err_q    <= 1'b0;
      d_done_q   <= 1'b0;
    end else begin
      i_valid_q <= 1'b0;
      i_err_q   <= 1'b0;
      d_done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!w_i_req) begin
            starve_q <= '0;
          end
          if (w_grant_data) begin
            state_q    <= DATA;
            m_addr_q   <= {bus.d_addr[31:2], 2'b00};
            m_byteen_q <= bus.d_byteen;
            if (bus.d_write) begin
              m_write_q <= 1'b1;
              m_wdata_q <= bus.d_wdata;
            end else begin
              m_read_q  <= 1'b1;
            end
            if (w_i_req && (starve_q < c_starve_max)) begin
              starve_q <= starve_q + c_cnt_w'(1);
            end
          end else if (w_fetch_ok) begin
            state_q    <= FETCH;
            m_read_q   <= 1'b1;
            m_addr_q   <= {bus.i_addr[31:2], 2'b00};
            m_byteen_q <= 4'hF;
            starve_q   <= '0;
          end else if (w_i_req) begin
            i_err_q  <= 1'b1;
            starve_q <= '0;
          end
        end
        FETCH, DATA: begin
          // Completion pulse is raised at accept so it lands in the RESP cycle.
          if (!bus.m_waitrequest) begin
            m_read_q  <= 1'b0;
            m_write_q <= 1'b0;
            state_q   <= RESP;
            if (state_q == FETCH) begin
              i_rdata_q <= bus.m_rdata;
              i_valid_q <= 1'b1;
            end else begin
              if (!m_write_q) begin
                d_rdata_q <= bus.m_rdata;
              end
              d_done_q <= 1'b1;
            end
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.m_read    = m_read_q;
  assign bus.m_write   = m_write_q;
  assign bus.m_addr    = m_addr_q;
  assign bus.m_wdata   = m_wdata_q;
  assign bus.m_byteen  = m_byteen_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.i_valid   = i_valid_q;
  assign bus.i_err     = i_err_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_done    = d_done_q;
  assign bus.boot_addr = RESET_VECTOR;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Scoreboard bench for mem_port_arbiter: directed cases plus random traffic
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        wr;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;
  bit   auto_slave;

  exp_t fq[$];
  exp_t dq[$];
  bit   glog[$];

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .RESET_VECTOR (32'hBFC00000),
    .STARVE_LIMIT (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_data(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic int glog_code();
    int code = 0;
    foreach (glog[i]) code = (code << 1) | int'(glog[i]);
    return code;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bad(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got event, expected none", name);
  endtask

  // Response monitor: pops the requester queues whenever a completion pulse shows.
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("pulse_exclusive",
          {31'b0, (bus.i_valid & bus.i_err) | (bus.i_valid & bus.d_done) | (bus.i_err & bus.d_done)}, 32'd0);
      if (bus.i_valid || bus.i_err) begin
        if (fq.size() == 0) bad("fetch_resp_unexpected");
        else begin
          mon_e = fq.pop_front();
          chk("fetch_resp_is_err", {31'b0, bus.i_err}, {31'b0, mon_e.err});
          if (bus.i_valid) chk("i_rdata", bus.i_rdata, mon_e.rdata);
        end
      end
      if (bus.d_done) begin
        if (dq.size() == 0) bad("d_done_unexpected");
        else begin
          mon_e = dq.pop_front();
          if (!mon_e.wr) chk("d_rdata", bus.d_rdata, mon_e.rdata);
        end
      end
    end
  end

  // Bus slave and bus-side checks: stability under wait, strobe exclusivity, accepted ops.
  exp_t bus_e;
  bit          p_hold;
  logic        p_read, p_write;
  logic [31:0] p_addr, p_wdata;
  logic [3:0]  p_be;
  always begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      p_hold = 1'b0;
    end else begin
      chk("strobe_mutex", {31'b0, bus.m_read & bus.m_write}, 32'd0);
      if (p_hold) begin
        chk("hold_read",   {31'b0, bus.m_read},  {31'b0, p_read});
        chk("hold_write",  {31'b0, bus.m_write}, {31'b0, p_write});
        chk("hold_addr",   bus.m_addr,  p_addr);
        chk("hold_wdata",  bus.m_wdata, p_wdata);
        chk("hold_byteen", {28'b0, bus.m_byteen}, {28'b0, p_be});
      end
      if (auto_slave) begin
        bus.m_waitrequest = ($urandom_range(0, 99) < 35);
        bus.m_rdata       = word_data(bus.m_addr);
      end
      if ((bus.m_read || bus.m_write) && !bus.m_waitrequest) begin
        if (bus.m_addr[31]) begin
          glog.push_back(1'b1);
          if (fq.size() == 0) bad("bus_fetch_unexpected");
          else begin
            bus_e = fq[0];
            chk("bus_fetch_read", {30'b0, bus.m_write, bus.m_read}, 32'd1);
            chk("bus_fetch_addr", bus.m_addr, {bus_e.addr[31:2], 2'b00});
            chk("bus_fetch_be",   {28'b0, bus.m_byteen}, 32'hF);
          end
        end else begin
          glog.push_back(1'b0);
          if (dq.size() == 0) bad("bus_data_unexpected");
          else begin
            bus_e = dq[0];
            chk("bus_data_write", {30'b0, bus.m_write, bus.m_read}, bus_e.wr ? 32'd2 : 32'd1);
            chk("bus_data_addr",  bus.m_addr, {bus_e.addr[31:2], 2'b00});
            chk("bus_data_be",    {28'b0, bus.m_byteen}, {28'b0, bus_e.be});
            if (bus_e.wr) chk("bus_data_wdata", bus.m_wdata, bus_e.wdata);
          end
        end
      end
      p_hold  = (bus.m_read || bus.m_write) && bus.m_waitrequest;
      p_read  = bus.m_read;
      p_write = bus.m_write;
      p_addr  = bus.m_addr;
      p_wdata = bus.m_wdata;
      p_be    = bus.m_byteen;
    end
  end

  task automatic push_f(input logic [31:0] a, input logic [31:0] rd);
    exp_t e;
    e.addr = a; e.wdata = '0; e.be = 4'hF; e.wr = 1'b0;
    e.err = (a[1:0] != 2'b00); e.rdata = rd;
    fq.push_back(e);
  endtask

  task automatic push_d(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                        input logic [3:0] be, input logic [31:0] rd);
    exp_t e;
    e.addr = a; e.wdata = wd; e.be = be; e.wr = wr; e.err = 1'b0; e.rdata = rd;
    dq.push_back(e);
  endtask

  logic [31:0] fa, da, dwd;
  logic [3:0]  dbe;
  int          kind, c_a, c_b, n_d;
  bit          flag, got;

  initial begin
    n_cmp = 0; n_fail = 0; auto_slave = 1'b0;
    rst_n = 1'b0;
    bus.i_req = 0; bus.i_addr = 0; bus.d_read = 0; bus.d_write = 0;
    bus.d_addr = 0; bus.d_wdata = 0; bus.d_byteen = 0;
    bus.m_waitrequest = 0; bus.m_rdata = 0;

    repeat (3) @(negedge clk);
    chk("rst_m_read",   {31'b0, bus.m_read},  32'd0);
    chk("rst_m_write",  {31'b0, bus.m_write}, 32'd0);
    chk("rst_m_addr",   bus.m_addr,  32'd0);
    chk("rst_m_wdata",  bus.m_wdata, 32'd0);
    chk("rst_m_byteen", {28'b0, bus.m_byteen}, 32'd0);
    chk("rst_i_rdata",  bus.i_rdata, 32'd0);
    chk("rst_d_rdata",  bus.d_rdata, 32'd0);
    chk("rst_pulses",   {29'b0, bus.i_valid, bus.i_err, bus.d_done}, 32'd0);
    chk("boot_addr",    bus.boot_addr, 32'hBFC00000);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_m_read", {31'b0, bus.m_read}, 32'd0);

    // Boot fetch with zero wait states.
    bus.m_waitrequest = 0; bus.m_rdata = 32'h24020005;
    push_f(32'hBFC00000, 32'h24020005);
    bus.i_req = 1; bus.i_addr = 32'hBFC00000;
    @(negedge clk);
    chk("t1_c1_m_read", {31'b0, bus.m_read}, 32'd1);
    chk("t1_c1_m_addr", bus.m_addr, 32'hBFC00000);
    chk("t1_c1_byteen", {28'b0, bus.m_byteen}, 32'hF);
    chk("t1_c1_i_valid", {31'b0, bus.i_valid}, 32'd0);
    @(negedge clk);
    chk("t1_c2_i_valid", {31'b0, bus.i_valid}, 32'd1);
    chk("t1_c2_i_rdata", bus.i_rdata, 32'h24020005);
    chk("t1_c2_m_read", {31'b0, bus.m_read}, 32'd0);
    bus.i_req = 0;
    repeat (2) @(negedge clk);

    // Store held under three wait cycles.
    push_d(32'h00001006, 1'b1, 32'hDEADBEEF, 4'b1100, 32'h0);
    bus.d_write = 1; bus.d_addr = 32'h00001006; bus.d_wdata = 32'hDEADBEEF; bus.d_byteen = 4'b1100;
    bus.m_waitrequest = 1;
    c_a = 0; c_b = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (bus.m_write && bus.m_addr == 32'h00001004 && bus.m_wdata == 32'hDEADBEEF
          && bus.m_byteen == 4'b1100) c_a++;
      if (bus.d_done) c_b++;
      if (k == 4) bus.m_waitrequest = 0;
    end
    chk("t2_write_held_cycles", c_a, 32'd4);
    @(negedge clk);
    chk("t2_d_done_after_accept", {31'b0, bus.d_done}, 32'd1);
    chk("t2_no_early_done", c_b, 32'd0);
    bus.d_write = 0;
    @(negedge clk);
    chk("t2_single_done", {30'b0, bus.d_done, bus.m_write}, 32'd0);
    repeat (2) @(negedge clk);

    // Simultaneous fetch and load: data wins, fetch follows straight after RESP.
    bus.m_rdata = 32'hCAFEF00D;
    push_d(32'h00002000, 1'b0, 32'h0, 4'hF, 32'hCAFEF00D);
    push_f(32'hBFC00010, 32'hCAFEF00D);
    glog.delete();
    bus.d_read = 1; bus.d_addr = 32'h00002000; bus.d_byteen = 4'hF;
    bus.i_req = 1; bus.i_addr = 32'hBFC00010;
    c_a = -1; c_b = -1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bus.d_done)  begin c_a = c; bus.d_read = 0; end
      if (bus.i_valid) begin c_b = c; bus.i_req = 0; end
    end
    chk("t3_d_done_cycle", c_a, 32'd2);
    chk("t3_i_valid_cycle", c_b, 32'd5);
    chk("t3_grant_count", glog.size(), 32'd2);
    chk("t3_grant_order", glog_code(), 32'b01);

    // Continuous loads with a held fetch: starvation limit forces the fetch.
    glog.delete();
    bus.m_rdata = 32'h0BADF00D;
    push_d(32'h00003000, 1'b0, 32'h0, 4'hF, 32'h0BADF00D);
    push_f(32'hBFC00020, 32'h0BADF00D);
    bus.d_read = 1; bus.d_addr = 32'h00003000; bus.d_byteen = 4'hF;
    bus.i_req = 1; bus.i_addr = 32'hBFC00020;
    n_d = 0; flag = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (bus.d_done) begin
        n_d++;
        if (n_d < 6) begin
          bus.d_addr = bus.d_addr + 32'd4;
          push_d(bus.d_addr, 1'b0, 32'h0, 4'hF, 32'h0BADF00D);
        end else bus.d_read = 0;
      end
      if (bus.i_valid) begin flag = 1; bus.i_req = 0; end
      if (n_d == 6 && flag) break;
    end
    chk("t4_data_count", n_d, 32'd6);
    chk("t4_fetch_done", {31'b0, flag}, 32'd1);
    chk("t4_grant_count", glog.size(), 32'd7);
    chk("t4_grant_order", glog_code(), 32'b0000100);
    repeat (2) @(negedge clk);

    // Misaligned fetch.
    push_f(32'hBFC00002, 32'h0);
    bus.i_req = 1; bus.i_addr = 32'hBFC00002;
    c_a = -1; flag = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (bus.m_read) flag = 1;
      if (bus.i_err) begin c_a = c; bus.i_req = 0; end
    end
    chk("t5_i_err_cycle", c_a, 32'd1);
    chk("t5_no_m_read", {31'b0, flag}, 32'd0);

    // Reset in the middle of a stalled store.
    push_d(32'h00004000, 1'b1, 32'h12345678, 4'hF, 32'h0);
    bus.d_write = 1; bus.d_addr = 32'h00004000; bus.d_wdata = 32'h12345678; bus.d_byteen = 4'hF;
    bus.m_waitrequest = 1;
    @(negedge clk);
    @(negedge clk);
    chk("t6_m_write_before", {31'b0, bus.m_write}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_m_write_async", {31'b0, bus.m_write}, 32'd0);
    chk("t6_m_addr_async", bus.m_addr, 32'd0);
    dq.delete();
    bus.d_write = 0; bus.m_waitrequest = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    c_a = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.d_done || bus.m_write) c_a++;
    end
    chk("t6_no_done_after_reset", c_a, 32'd0);

    // Random concurrent traffic against the bus slave model.
    auto_slave = 1'b1;
    fork
      begin
        for (int t = 0; t < 40; t++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          fa = 32'hBFC00000 | ($urandom & 32'h0000FFFC);
          if ($urandom_range(0, 5) == 0) fa[1:0] = 2'($urandom_range(1, 3));
          push_f(fa, word_data({fa[31:2], 2'b00}));
          bus.i_req = 1; bus.i_addr = fa;
          got = 0;
          for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus.i_valid || bus.i_err) begin got = 1; break; end
          end
          if (!got) bad("fetch_timeout");
          bus.i_req = 0;
        end
      end
      begin
        for (int t = 0; t < 60; t++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          da = {16'h0000, 16'($urandom)};
          kind = $urandom_range(0, 2);
          dbe = 4'($urandom);
          dwd = $urandom;
          push_d(da, kind != 0, dwd, dbe, word_data({da[31:2], 2'b00}));
          bus.d_addr = da; bus.d_byteen = dbe; bus.d_wdata = dwd;
          bus.d_read = (kind != 1); bus.d_write = (kind != 0);
          flag = 0;
          for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus.d_done) begin flag = 1; break; end
          end
          if (!flag) bad("data_timeout");
          bus.d_read = 0; bus.d_write = 0;
        end
      end
    join
    repeat (5) @(negedge clk);
    chk("fetch_queue_drained", fq.size(), 32'd0);
    chk("data_queue_drained", dq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
